// File: rtl/amm_burst_writer_pkg.sv
// Shared types, widths and pattern helpers for the memory-checker write and read paths.
package amm_burst_writer_pkg;

    localparam int AMM_ADDR_W  = 32;
    localparam int AMM_DATA_W  = 512;
    localparam int AMM_BURST_W = 11;
    localparam int DEF_STAT_W  = 32;
    localparam int DATA_B_W    = AMM_DATA_W / 8;
    localparam int ADDR_B_W    = $clog2(DATA_B_W);

    localparam logic [7:0] LFSR_ZERO_SEED = 8'h01;

    typedef enum logic {IDLE_W, BURST_W} wr_state_t;
    typedef enum logic {FIX_DATA, RND_DATA} data_mode_t;

    typedef logic [AMM_ADDR_W-ADDR_B_W-1:0] start_addr_t;
    typedef logic [AMM_BURST_W-2:0]         words_t;
    typedef logic [ADDR_B_W-1:0]            boff_t;

    typedef struct packed {
        logic        trans_type;
        data_mode_t  data_mode;
        logic [7:0]  data_ptrn;
        start_addr_t start_addr;
        words_t      words_count;
        boff_t       start_off;
        boff_t       end_off;
    } cmp_struct_t;

    function automatic logic [7:0] lfsr8_next(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    // First beat trims below start_off, last beat trims above end_off; a single beat does both.
    function automatic logic [DATA_B_W-1:0] byteenable_ptrn(input logic  first,
                                                            input boff_t start_off,
                                                            input logic  last,
                                                            input boff_t end_off);
        logic [DATA_B_W-1:0] be;
        be = '0;
        for (int i = 0; i < DATA_B_W; i++) begin
            be[i] = (!first || (i >= int'(start_off))) && (!last || (i <= int'(end_off)));
        end
        return be;
    endfunction

endpackage

// File: rtl/amm_burst_writer_ptrn_data_gen.sv
// Beat data source: fixed byte pattern or 8-bit LFSR, replicated across the data bus.
module ptrn_data_gen
    import amm_burst_writer_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  load_i,
    input  data_mode_t            mode_i,
    input  logic [7:0]            ptrn_i,
    input  logic                  step_i,
    output logic [AMM_DATA_W-1:0] data_o
);

    data_mode_t r_mode;
    logic [7:0] r_ptrn;
    logic [7:0] r_lfsr;
    logic [7:0] w_byte;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_mode <= FIX_DATA;
            r_ptrn <= '0;
            r_lfsr <= LFSR_ZERO_SEED;
        end else if (load_i) begin
            r_mode <= mode_i;
            r_ptrn <= ptrn_i;
            // An all-zero LFSR would lock up
            r_lfsr <= (ptrn_i == 8'h00) ? LFSR_ZERO_SEED : ptrn_i;
        end else if (step_i) begin
            r_lfsr <= lfsr8_next(r_lfsr);
        end
    end

    assign w_byte = (r_mode == RND_DATA) ? r_lfsr : r_ptrn;
    assign data_o = {DATA_B_W{w_byte}};

endmodule

// File: rtl/amm_burst_writer.sv
// Drives one descriptor as an Avalon-MM burst write and keeps saturating write statistics.
// state   | meaning
// IDLE_W  | ready for a descriptor; drops trans_type=0 descriptors
// BURST_W | issuing beats until the last one is accepted
module amm_burst_writer
    import amm_burst_writer_pkg::*;
#(
    parameter string ADDR_TYPE = "BYTE",
    parameter int    STAT_W    = DEF_STAT_W
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   cmd_valid_i,
    input  cmp_struct_t            cmd_i,
    output logic                   cmd_ready_o,
    output logic                   cmd_drop_o,
    output logic [AMM_ADDR_W-1:0]  amm_address_o,
    output logic                   amm_write_o,
    output logic [AMM_DATA_W-1:0]  amm_writedata_o,
    output logic [DATA_B_W-1:0]    amm_byteenable_o,
    output logic [AMM_BURST_W-1:0] amm_burstcount_o,
    input  logic                   amm_waitrequest_i,
    output logic                   busy_o,
    output logic                   done_o,
    input  logic                   stat_clr_i,
    output logic [STAT_W-1:0]      wr_ticks_o,
    output logic [STAT_W-1:0]      wr_units_o
);

    wr_state_t             r_state;
    wr_state_t             w_next_state;
    start_addr_t           r_start_addr;
    words_t                r_words;
    boff_t                 r_start_off;
    boff_t                 r_end_off;
    words_t                r_beats_left;
    logic                  r_first;
    logic                  r_drop;
    logic                  r_done;
    logic [STAT_W-1:0]     r_ticks;
    logic [STAT_W-1:0]     r_units;
    logic                  w_accept;
    logic                  w_start;
    logic                  w_beat_acc;
    logic                  w_last;
    logic [AMM_ADDR_W-1:0] w_addr;
    logic [AMM_DATA_W-1:0] w_data;

    assign w_accept   = cmd_valid_i && cmd_ready_o;
    assign w_start    = w_accept && cmd_i.trans_type;
    assign w_beat_acc = amm_write_o && !amm_waitrequest_i;
    assign w_last     = (r_beats_left == '0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= IDLE_W;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE_W:  if (w_start) w_next_state = BURST_W;
            BURST_W: if (w_beat_acc && w_last) w_next_state = IDLE_W;
            default: w_next_state = IDLE_W;
        endcase
    end

    always_comb begin
        cmd_ready_o = 1'b0;
        amm_write_o = 1'b0;
        busy_o      = 1'b0;
        case (r_state)
            IDLE_W:  cmd_ready_o = 1'b1;
            BURST_W: begin
                amm_write_o = 1'b1;
                busy_o      = 1'b1;
            end
            default: cmd_ready_o = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_start_addr <= '0;
            r_words      <= '0;
            r_start_off  <= '0;
            r_end_off    <= '0;
            r_beats_left <= '0;
            r_first      <= 1'b0;
            r_drop       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_drop <= w_accept && !cmd_i.trans_type;
            r_done <= w_beat_acc && w_last;
            if (w_start) begin
                r_start_addr <= cmd_i.start_addr;
                r_words      <= cmd_i.words_count;
                r_start_off  <= cmd_i.start_off;
                r_end_off    <= cmd_i.end_off;
                r_beats_left <= cmd_i.words_count;
                r_first      <= 1'b1;
            end else if (w_beat_acc) begin
                r_beats_left <= r_beats_left - words_t'(1);
                r_first      <= 1'b0;
            end
        end
    end

    ptrn_data_gen u_ptrn (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .load_i (w_start),
        .mode_i (cmd_i.data_mode),
        .ptrn_i (cmd_i.data_ptrn),
        .step_i (w_beat_acc),
        .data_o (w_data)
    );

    generate
        if (ADDR_TYPE == "BYTE") begin : g_byte_addr
            assign w_addr = AMM_ADDR_W'({r_start_addr, {ADDR_B_W{1'b0}}});
        end else begin : g_word_addr
            assign w_addr = AMM_ADDR_W'(r_start_addr);
        end
    endgenerate

    // Bus fields are zero outside a burst so the reset and idle bus is quiet
    assign amm_address_o    = busy_o ? w_addr : '0;
    assign amm_writedata_o  = busy_o ? w_data : '0;
    assign amm_byteenable_o = busy_o ? byteenable_ptrn(r_first, r_start_off, w_last, r_end_off) : '0;
    assign amm_burstcount_o = busy_o ? (AMM_BURST_W'(r_words) + AMM_BURST_W'(1)) : '0;
    assign cmd_drop_o       = r_drop;
    assign done_o           = r_done;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ticks <= '0;
            r_units <= '0;
        end else if (stat_clr_i) begin
            r_ticks <= '0;
            r_units <= '0;
        end else begin
            if (busy_o && (r_ticks != '1))    r_ticks <= r_ticks + STAT_W'(1);
            if (w_beat_acc && (r_units != '1)) r_units <= r_units + STAT_W'(1);
        end
    end

    assign wr_ticks_o = r_ticks;
    assign wr_units_o = r_units;

endmodule

// File: tb/tb_amm_burst_writer.sv
// Directed bench for amm_burst_writer: vector table plus hand-written multi-cycle sequences.
module tb_amm_burst_writer;
    import amm_burst_writer_pkg::*;

    localparam int SW = 8;

    logic                   clk_i = 1'b0;
    logic                   rst_i;
    logic                   cmd_valid_i;
    cmp_struct_t            cmd_i;
    logic                   cmd_ready_o;
    logic                   cmd_drop_o;
    logic [AMM_ADDR_W-1:0]  amm_address_o;
    logic                   amm_write_o;
    logic [AMM_DATA_W-1:0]  amm_writedata_o;
    logic [DATA_B_W-1:0]    amm_byteenable_o;
    logic [AMM_BURST_W-1:0] amm_burstcount_o;
    logic                   amm_waitrequest_i;
    logic                   busy_o;
    logic                   done_o;
    logic                   stat_clr_i;
    logic [SW-1:0]          wr_ticks_o;
    logic [SW-1:0]          wr_units_o;

    int total = 0;
    int bad   = 0;

    amm_burst_writer #(.ADDR_TYPE("BYTE"), .STAT_W(SW)) dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .cmd_valid_i       (cmd_valid_i),
        .cmd_i             (cmd_i),
        .cmd_ready_o       (cmd_ready_o),
        .cmd_drop_o        (cmd_drop_o),
        .amm_address_o     (amm_address_o),
        .amm_write_o       (amm_write_o),
        .amm_writedata_o   (amm_writedata_o),
        .amm_byteenable_o  (amm_byteenable_o),
        .amm_burstcount_o  (amm_burstcount_o),
        .amm_waitrequest_i (amm_waitrequest_i),
        .busy_o            (busy_o),
        .done_o            (done_o),
        .stat_clr_i        (stat_clr_i),
        .wr_ticks_o        (wr_ticks_o),
        .wr_units_o        (wr_units_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        cmp_struct_t cmd;
        int          stall_beat;
        int          stall_n;
        int          beats;
        logic [31:0] exp_addr;
        logic [10:0] exp_bc;
        logic [63:0] exp_be_first;
        logic [63:0] exp_be_last;
        logic [39:0] exp_bytes;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic cmp_struct_t mk_cmd(input logic tt, input data_mode_t m, input logic [7:0] p,
                                           input int addr, input int words, input int so, input int eo);
        cmp_struct_t c;
        c.trans_type  = tt;
        c.data_mode   = m;
        c.data_ptrn   = p;
        c.start_addr  = start_addr_t'(addr);
        c.words_count = words_t'(words);
        c.start_off   = boff_t'(so);
        c.end_off     = boff_t'(eo);
        return c;
    endfunction

    task automatic clear_stats();
        stat_clr_i = 1'b1;
        @(negedge clk_i);
        stat_clr_i = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int cyc = 0;
        while (!done_o && cyc < budget) begin
            @(negedge clk_i);
            cyc++;
        end
        chk({name, "_done_seen"}, done_o, 1'b1);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int          beat = 0;
        int          stalled = 0;
        logic [63:0] be_exp;
        logic [7:0]  b;
        string       n;
        n = $sformatf("v%0d", idx);
        clear_stats();
        cmd_i = v.cmd;
        cmd_valid_i = 1'b1;
        chk({n, "_ready"}, cmd_ready_o, 1'b1);
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
        while (beat < v.beats) begin
            be_exp = (beat == 0) ? v.exp_be_first : (beat == v.beats - 1) ? v.exp_be_last : '1;
            b = v.exp_bytes[8*beat +: 8];
            chk($sformatf("%s_b%0d_write", n, beat), amm_write_o, 1'b1);
            chk($sformatf("%s_b%0d_addr", n, beat), amm_address_o, v.exp_addr);
            chk($sformatf("%s_b%0d_bc", n, beat), amm_burstcount_o, v.exp_bc);
            chk($sformatf("%s_b%0d_be", n, beat), amm_byteenable_o, be_exp);
            chk($sformatf("%s_b%0d_data", n, beat), amm_writedata_o, {DATA_B_W{b}});
            if (beat == v.stall_beat && stalled < v.stall_n) begin
                amm_waitrequest_i = 1'b1;
                stalled++;
            end else begin
                amm_waitrequest_i = 1'b0;
                beat++;
            end
            @(negedge clk_i);
        end
        amm_waitrequest_i = 1'b0;
        chk({n, "_done"}, done_o, 1'b1);
        chk({n, "_write_after"}, amm_write_o, 1'b0);
        chk({n, "_ready_after"}, cmd_ready_o, 1'b1);
        chk({n, "_units"}, wr_units_o, SW'(v.beats));
        chk({n, "_ticks"}, wr_ticks_o, SW'(v.beats + v.stall_n));
        @(negedge clk_i);
        chk({n, "_done_gone"}, done_o, 1'b0);
    endtask

    initial begin
        logic [4:0] wr_pat;
        logic [4:0] dn_pat;

        vecs[0] = '{mk_cmd(1'b1, FIX_DATA, 8'hA5, 5, 0, 3, 60), -1, 0, 1,
                    32'h140, 11'd1, 64'h1FFF_FFFF_FFFF_FFF8, 64'h1FFF_FFFF_FFFF_FFF8, 40'hA5A5A5A5A5};
        vecs[1] = '{mk_cmd(1'b1, FIX_DATA, 8'h3C, 2, 3, 10, 7), 1, 2, 4,
                    32'h80, 11'd4, 64'hFFFF_FFFF_FFFF_FC00, 64'h0000_0000_0000_00FF, 40'h3C3C3C3C3C};
        vecs[2] = '{mk_cmd(1'b1, RND_DATA, 8'h00, 16, 4, 0, 63), -1, 0, 5,
                    32'h400, 11'd5, '1, '1, 40'h11_08_04_02_01};
        vecs[3] = '{mk_cmd(1'b1, FIX_DATA, 8'h5A, 7, 0, 10, 5), -1, 0, 1,
                    32'h1C0, 11'd1, 64'h0, 64'h0, 40'h5A5A5A5A5A};
        vecs[4] = '{mk_cmd(1'b1, RND_DATA, 8'h80, 1, 1, 4, 9), 0, 1, 2,
                    32'h40, 11'd2, 64'hFFFF_FFFF_FFFF_FFF0, 64'h0000_0000_0000_03FF, 40'h00_00_00_01_80};

        rst_i = 1'b1;
        cmd_valid_i = 1'b0;
        cmd_i = '0;
        amm_waitrequest_i = 1'b0;
        stat_clr_i = 1'b0;
        repeat (2) @(negedge clk_i);
        chk("rst_ready", cmd_ready_o, 1'b1);
        chk("rst_write", amm_write_o, 1'b0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_done", done_o, 1'b0);
        chk("rst_drop", cmd_drop_o, 1'b0);
        chk("rst_be", amm_byteenable_o, 64'h0);
        chk("rst_units", wr_units_o, 8'h0);
        chk("rst_ticks", wr_ticks_o, 8'h0);
        rst_i = 1'b0;
        @(negedge clk_i);

        for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

        // descriptor with trans_type=0 is dropped
        clear_stats();
        cmd_i = mk_cmd(1'b0, FIX_DATA, 8'h77, 4, 2, 0, 63);
        cmd_valid_i = 1'b1;
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
        chk("drop_pulse", cmd_drop_o, 1'b1);
        chk("drop_write", amm_write_o, 1'b0);
        chk("drop_busy", busy_o, 1'b0);
        @(negedge clk_i);
        chk("drop_pulse_end", cmd_drop_o, 1'b0);
        chk("drop_write2", amm_write_o, 1'b0);
        chk("drop_units", wr_units_o, 8'h0);
        chk("drop_ticks", wr_ticks_o, 8'h0);

        // back-to-back: two beats, one idle, one beat, idle
        cmd_i = mk_cmd(1'b1, FIX_DATA, 8'h11, 3, 1, 0, 63);
        cmd_valid_i = 1'b1;
        @(negedge clk_i);
        cmd_i = mk_cmd(1'b1, FIX_DATA, 8'h22, 9, 0, 0, 63);
        for (int k = 0; k < 5; k++) begin
            wr_pat[4-k] = amm_write_o;
            dn_pat[4-k] = done_o;
            if (k == 3) begin
                chk("b2b_addr_b", amm_address_o, 32'h240);
                chk("b2b_data_b", amm_writedata_o, {DATA_B_W{8'h22}});
                cmd_valid_i = 1'b0;
            end
            @(negedge clk_i);
        end
        chk("b2b_write_pattern", wr_pat, 5'b11010);
        chk("b2b_done_pattern", dn_pat, 5'b00101);

        // saturation: 300 beats into 8-bit counters
        clear_stats();
        cmd_i = mk_cmd(1'b1, FIX_DATA, 8'h33, 0, 299, 0, 63);
        cmd_valid_i = 1'b1;
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
        wait_done("sat", 1000);
        chk("sat_units", wr_units_o, 8'hFF);
        chk("sat_ticks", wr_ticks_o, 8'hFF);

        // clear coinciding with a beat accept
        cmd_i = mk_cmd(1'b1, FIX_DATA, 8'h44, 1, 3, 0, 63);
        cmd_valid_i = 1'b1;
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
        chk("clr_beat_write", amm_write_o, 1'b1);
        stat_clr_i = 1'b1;
        @(negedge clk_i);
        stat_clr_i = 1'b0;
        chk("clr_units_zero", wr_units_o, 8'h0);
        chk("clr_ticks_zero", wr_ticks_o, 8'h0);
        wait_done("clr", 50);
        chk("clr_units_rest", wr_units_o, 8'd3);
        chk("clr_ticks_rest", wr_ticks_o, 8'd3);
        @(negedge clk_i);

        // reset in the middle of a burst
        cmd_i = mk_cmd(1'b1, FIX_DATA, 8'h55, 2, 9, 0, 63);
        cmd_valid_i = 1'b1;
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
        repeat (2) @(negedge clk_i);
        chk("mid_write_before", amm_write_o, 1'b1);
        #2 rst_i = 1'b1;
        #1;
        chk("mid_write_async", amm_write_o, 1'b0);
        chk("mid_busy_async", busy_o, 1'b0);
        chk("mid_ready_async", cmd_ready_o, 1'b1);
        @(negedge clk_i);
        rst_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("mid_no_done_%0d", k), {done_o, amm_write_o}, 2'b00);
            @(negedge clk_i);
        end
        chk("mid_units", wr_units_o, 8'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
